// File: rtl/snake_pkg.sv
// Shared direction codes, key bit indices and direction helpers for the snake
// direction arbiter.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  localparam dir_t DIR_RESET = DIR_RIGHT;

  localparam int unsigned IR_W       = 7;
  localparam int unsigned BTN_W      = 4;
  localparam int unsigned IR_UP      = 0;
  localparam int unsigned IR_DOWN    = 1;
  localparam int unsigned IR_LEFT    = 2;
  localparam int unsigned IR_RIGHT   = 3;
  localparam int unsigned IR_START   = 4;
  localparam int unsigned IR_PAUSE   = 5;
  localparam int unsigned IR_RESTART = 6;

  typedef struct packed {
    logic valid;
    dir_t dir;
  } dir_req_t;

  // Codes are paired so the opposite direction differs only in bit 0.
  function automatic dir_t dir_reverse(input dir_t d);
    return dir_t'({d[1], ~d[0]});
  endfunction

  // Lowest set bit wins: UP > DOWN > LEFT > RIGHT.
  function automatic dir_req_t pick_dir(input logic [3:0] rise);
    dir_req_t r;
    r.valid = |rise;
    r.dir   = DIR_UP;
    if (rise[0])      r.dir = DIR_UP;
    else if (rise[1]) r.dir = DIR_DOWN;
    else if (rise[2]) r.dir = DIR_LEFT;
    else if (rise[3]) r.dir = DIR_RIGHT;
    return r;
  endfunction

endpackage

// File: rtl/snake_dir_arbiter_edge.sv
// Per-bit rising-edge detector: registers the previous level and flags 0->1.
module key_edge_detect #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [WIDTH-1:0] key,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] key_prev;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) key_prev <= '0;
    else            key_prev <= key;
  end

  assign rise = key & ~key_prev;

endmodule

// File: rtl/snake_dir_arbiter.sv
// Merges IR and pushbutton direction requests into a filtered FIFO applied one
// per game tick, and sequences start / pause / restart.
module snake_dir_arbiter
  import snake_pkg::*;
#(
  parameter int unsigned QDEPTH = 2
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst_n,
  input  logic [6:0]                ir_key,
  input  logic [3:0]                btn_key,
  input  logic                      game_tick,
  output logic [1:0]                dir,
  output logic                      dir_changed,
  output logic                      paused,
  output logic                      cmd_restart,
  output logic [$clog2(QDEPTH):0]   q_count,
  output logic                      q_overflow
);

  localparam int unsigned AW = $clog2(QDEPTH);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_PAUSE = 1'b1
  } run_state_t;

  logic [IR_W-1:0]  ir_rise;
  logic [BTN_W-1:0] btn_rise;

  key_edge_detect #(.WIDTH(IR_W)) u_ir_edge (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key       (ir_key),
    .rise      (ir_rise)
  );

  key_edge_detect #(.WIDTH(BTN_W)) u_btn_edge (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key       (btn_key),
    .rise      (btn_rise)
  );

  run_state_t state;
  dir_t       dir_q;
  dir_t       mem [QDEPTH];
  logic [AW:0] wr_ptr, rd_ptr, wr_last;

  dir_req_t btn_req, ir_req, req;
  dir_t     ref_dir;
  logic     do_restart, do_start, do_pause;
  logic     empty, full, accepted, pop, push, ovf_set;

  assign do_restart = ir_rise[IR_RESTART];
  assign do_start   = ir_rise[IR_START];
  assign do_pause   = ir_rise[IR_PAUSE];

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign wr_last = wr_ptr - 1'b1;

  always_comb begin
    btn_req = pick_dir(btn_rise);
    ir_req  = pick_dir(ir_rise[IR_RIGHT:IR_UP]);
    req     = btn_req.valid ? btn_req : ir_req;
    ref_dir = empty ? dir_q : mem[wr_last[AW-1:0]];
  end

  // A pop in the same cycle frees the slot a full FIFO needs for the push;
  // the tail (filter reference) is unaffected by the pop.
  assign accepted = req.valid && (req.dir != ref_dir) && (req.dir != dir_reverse(ref_dir));
  assign pop      = game_tick && !paused && !empty;
  assign push     = accepted && !paused && !do_restart && (!full || pop);
  assign ovf_set  = accepted && !paused && !do_restart && full && !pop;

  always_ff @(posedge sys_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= req.dir;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      dir_q       <= DIR_RESET;
      dir_changed <= 1'b0;
      q_overflow  <= 1'b0;
      cmd_restart <= 1'b0;
    end else begin
      dir_changed <= 1'b0;
      cmd_restart <= do_restart;
      if (do_restart) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        dir_q      <= DIR_RESET;
        q_overflow <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop) begin
          dir_q       <= mem[rd_ptr[AW-1:0]];
          rd_ptr      <= rd_ptr + 1'b1;
          dir_changed <= 1'b1;
        end
        if (ovf_set) q_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state  <= ST_PAUSE;
      paused <= 1'b1;
    end else begin
      if (do_restart) begin
        state  <= ST_PAUSE;
        paused <= 1'b1;
      end else if (do_start) begin
        state  <= ST_RUN;
        paused <= 1'b0;
      end else if (do_pause) begin
        state  <= (state == ST_PAUSE) ? ST_RUN : ST_PAUSE;
        paused <= (state != ST_PAUSE);
      end
    end
  end

  assign dir     = dir_q;
  assign q_count = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_snake_dir_arbiter.sv
// Directed self-checking bench for snake_dir_arbiter with QDEPTH=2.
module tb_snake_dir_arbiter;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic [6:0] ir_key;
  logic [3:0] btn_key;
  logic       game_tick;
  logic [1:0] dir;
  logic       dir_changed;
  logic       paused;
  logic       cmd_restart;
  logic [1:0] q_count;
  logic       q_overflow;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  localparam logic [6:0] K_UP = 7'h01, K_DOWN = 7'h02, K_LEFT = 7'h04, K_RIGHT = 7'h08;
  localparam logic [6:0] K_START = 7'h10, K_PAUSE = 7'h20, K_RESTART = 7'h40;

  snake_dir_arbiter #(.QDEPTH(2)) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .ir_key      (ir_key),
    .btn_key     (btn_key),
    .game_tick   (game_tick),
    .dir         (dir),
    .dir_changed (dir_changed),
    .paused      (paused),
    .cmd_restart (cmd_restart),
    .q_count     (q_count),
    .q_overflow  (q_overflow)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic [6:0] ir, input logic [3:0] btn);
    ir_key  = ir;
    btn_key = btn;
    tick();
    ir_key  = '0;
    btn_key = '0;
    tick();
  endtask

  task automatic gtick();
    game_tick = 1'b1;
    tick();
    game_tick = 1'b0;
  endtask

  initial begin
    sys_rst_n = 1'b0;
    ir_key    = '0;
    btn_key   = '0;
    game_tick = 1'b0;
    tick();
    tick();
    chk("rst_dir", dir, 3);
    chk("rst_dir_changed", dir_changed, 0);
    chk("rst_paused", paused, 1);
    chk("rst_cmd_restart", cmd_restart, 0);
    chk("rst_q_count", q_count, 0);
    chk("rst_q_overflow", q_overflow, 0);
    sys_rst_n = 1'b1;
    tick();

    // START, then IR UP held long: single enqueue
    ir_key = K_START;
    tick();
    chk("start_paused", paused, 0);
    ir_key = '0;
    tick();
    ir_key = K_UP;
    repeat (5000) tick();
    chk("held_up_q_count", q_count, 1);
    ir_key = '0;
    tick();
    chk("held_up_dir_before_tick", dir, 3);
    gtick();
    chk("pop_up_dir", dir, 0);
    chk("pop_up_dir_changed", dir_changed, 1);
    chk("pop_up_q_count", q_count, 0);
    tick();
    chk("dir_changed_one_cycle", dir_changed, 0);

    // RESTART to get back to RIGHT, then START
    ir_key = K_RESTART;
    tick();
    chk("restart1_cmd", cmd_restart, 1);
    chk("restart1_dir", dir, 3);
    chk("restart1_paused", paused, 1);
    ir_key = '0;
    tick();
    chk("restart1_cmd_low", cmd_restart, 0);
    pulse(K_START, '0);
    chk("start2_paused", paused, 0);

    // Filter: reverse and repeat rejected
    pulse(K_LEFT, '0);
    chk("reverse_rejected", q_count, 0);
    pulse(K_RIGHT, '0);
    chk("repeat_rejected", q_count, 0);
    pulse(K_UP, '0);
    chk("up_queued", q_count, 1);
    pulse(K_DOWN, '0);
    chk("down_vs_tail_rejected", q_count, 1);
    chk("no_overflow_on_reject", q_overflow, 0);
    gtick();
    chk("filter_pop_dir", dir, 0);
    chk("filter_pop_q_count", q_count, 0);

    // Button beats IR
    pulse(K_UP, 4'b0100);
    chk("btn_left_vs_ir_up_q", q_count, 1);
    gtick();
    chk("btn_left_wins_dir", dir, 2);
    pulse(K_UP, 4'b0010);
    chk("btn_down_vs_ir_up_q", q_count, 1);
    gtick();
    chk("btn_down_wins_dir", dir, 1);
    pulse('0, 4'b1100);
    gtick();
    chk("btn_lowest_bit_wins", dir, 2);

    // Overflow with QDEPTH=2
    pulse(K_UP, '0);
    pulse(K_LEFT, '0);
    chk("fill_q_count", q_count, 2);
    chk("fill_no_overflow", q_overflow, 0);
    pulse(K_DOWN, '0);
    chk("full_drop_q_count", q_count, 2);
    chk("full_drop_overflow", q_overflow, 1);
    ir_key    = K_DOWN;
    game_tick = 1'b1;
    tick();
    ir_key    = '0;
    game_tick = 1'b0;
    chk("push_pop_full_q_count", q_count, 2);
    chk("push_pop_full_dir", dir, 0);
    chk("push_pop_full_changed", dir_changed, 1);
    chk("overflow_sticky", q_overflow, 1);
    gtick();
    chk("drain1_dir", dir, 2);
    chk("drain1_q_count", q_count, 1);

    // Pause freezes ticks and keys
    pulse(K_PAUSE, '0);
    chk("pause_paused", paused, 1);
    gtick();
    chk("paused_tick_q_count", q_count, 1);
    chk("paused_tick_dir", dir, 2);
    chk("paused_tick_no_change", dir_changed, 0);
    pulse(K_RIGHT, '0);
    chk("paused_key_ignored", q_count, 1);
    pulse(K_PAUSE, '0);
    chk("resume_paused", paused, 0);
    gtick();
    chk("resume_pop_dir", dir, 1);
    chk("resume_pop_changed", dir_changed, 1);
    chk("resume_pop_q_count", q_count, 0);

    // RESTART with two entries queued and overflow set
    pulse(K_LEFT, '0);
    pulse(K_UP, '0);
    pulse(K_RIGHT, '0);
    chk("pre_restart_q_count", q_count, 2);
    chk("pre_restart_overflow", q_overflow, 1);
    ir_key = K_RESTART;
    tick();
    chk("restart2_q_count", q_count, 0);
    chk("restart2_dir", dir, 3);
    chk("restart2_paused", paused, 1);
    chk("restart2_overflow", q_overflow, 0);
    chk("restart2_cmd", cmd_restart, 1);
    ir_key = '0;
    tick();
    chk("restart2_cmd_low", cmd_restart, 0);

    // Asynchronous reset while IR UP is held
    pulse(K_START, '0);
    ir_key = K_UP;
    tick();
    chk("pre_reset_q_count", q_count, 1);
    sys_rst_n = 1'b0;
    #2;
    chk("async_reset_q_count", q_count, 0);
    chk("async_reset_paused", paused, 1);
    tick();
    tick();
    sys_rst_n = 1'b1;
    tick();
    ir_key = K_UP | K_START;
    tick();
    ir_key = K_UP;
    chk("post_reset_start", paused, 0);
    repeat (10) tick();
    chk("held_no_retrigger", q_count, 0);
    ir_key = '0;
    tick();
    ir_key = K_UP;
    tick();
    chk("new_edge_enqueues", q_count, 1);
    ir_key = '0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
